// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the IF-stage PC generator and its neighbours
// (hazard unit, ID branch resolution, exception unit, instruction ROM).
interface pc_gen_if;
    logic        stall;
    logic        flush;
    logic [31:0] exc_pc;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        rom_ready;
    logic        rom_en;
    logic [31:0] pc;
    logic        branch_pending;
    logic        addr_err;

    // pc_gen issues fetch requests, so it is the master of this bundle
    modport master (
        input  stall, flush, exc_pc, branch_flag, branch_addr, rom_ready,
        output rom_en, pc, branch_pending, addr_err
    );

    modport slave (
        output stall, flush, exc_pc, branch_flag, branch_addr, rom_ready,
        input  rom_en, pc, branch_pending, addr_err
    );
endinterface

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: sequential / branch / buffered-branch / flush.
// Optional misaligned-target check enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_gen_if.master  bus
);

    typedef enum logic [1:0] {INIT, RUN, HOLD} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pend_addr;
    logic        rom_en_q;
    logic        pending_q;
    logic        advance;
    logic [31:0] ld_src;
    logic [31:0] ld_tgt;

    assign advance = (state != INIT) & bus.rom_ready & ~bus.stall;

    // A fresh branch from ID wins over the buffered one when both could load
    assign ld_src = bus.branch_flag ? bus.branch_addr : pend_addr;

`ifdef PC_ALIGN_CHECK_EN
    logic ld_err;
    logic err_q;

    always_comb begin
        ld_tgt = {ld_src[31:2], 2'b00};
        ld_err = |ld_src[1:0];
    end

    // Follows the pc value it flags: set on a misaligned load, cleared on any other change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (bus.flush) begin
            err_q <= 1'b0;
        end else if (advance) begin
            if (bus.branch_flag || state == HOLD)
                err_q <= ld_err;
            else
                err_q <= 1'b0;
        end
    end

    assign bus.addr_err = err_q;
`else
    assign ld_tgt       = ld_src;
    assign bus.addr_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            pc_q      <= RESET_PC;
            pend_addr <= 32'h0;
            rom_en_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    // First fetch is RESET_PC itself, not RESET_PC+step
                    if (bus.flush)
                        pc_q <= bus.exc_pc;
                    state     <= RUN;
                    rom_en_q  <= 1'b1;
                    pending_q <= 1'b0;
                end
                RUN, HOLD: begin
                    rom_en_q <= 1'b1;
                    if (bus.flush) begin
                        pc_q      <= bus.exc_pc;
                        state     <= RUN;
                        pending_q <= 1'b0;
                    end else if (advance && (bus.branch_flag || state == HOLD)) begin
                        pc_q      <= ld_tgt;
                        state     <= RUN;
                        pending_q <= 1'b0;
                    end else if (advance) begin
                        pc_q <= pc_q + PC_STEP;
                    end else if (bus.branch_flag) begin
                        // Only the latest target survives a stall
                        pend_addr <= bus.branch_addr;
                        state     <= HOLD;
                        pending_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= INIT;
                    rom_en_q  <= 1'b0;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc             = pc_q;
    assign bus.rom_en         = rom_en_q;
    assign bus.branch_pending = pending_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed + randomized bench for pc_gen against a queue-based reference model.
module tb_pc_gen;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pc_gen_if bus ();

    pc_gen #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: "fetching" flag, pc, error flag, and at most one buffered target
    bit          m_started;
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_pend[$];

    task automatic model_reset();
        m_started = 0;
        m_pc      = RST_PC;
        m_err     = 1'b0;
        m_pend.delete();
    endtask

    task automatic model_load(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        m_pc  = t & 32'hFFFF_FFFC;
        m_err = (t % 4) != 0;
`else
        m_pc  = t;
        m_err = 1'b0;
`endif
    endtask

    task automatic model_edge();
        bit adv;
        if (!m_started) begin
            if (bus.flush) m_pc = bus.exc_pc;
            m_started = 1;
            m_err     = 1'b0;
        end else begin
            adv = bus.rom_ready && !bus.stall;
            if (bus.flush) begin
                m_pc = bus.exc_pc;
                m_err = 1'b0;
                m_pend.delete();
            end else if (adv && bus.branch_flag) begin
                model_load(bus.branch_addr);
                m_pend.delete();
            end else if (adv && m_pend.size() != 0) begin
                model_load(m_pend[0]);
                m_pend.delete();
            end else if (adv) begin
                m_pc  = m_pc + 32'd4;
                m_err = 1'b0;
            end else if (bus.branch_flag) begin
                m_pend.delete();
                m_pend.push_back(bus.branch_addr);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("pc", bus.pc, m_pc);
        chk("rom_en", {31'b0, bus.rom_en}, {31'b0, m_started});
        chk("branch_pending", {31'b0, bus.branch_pending}, {31'b0, m_pend.size() != 0});
        chk("addr_err", {31'b0, bus.addr_err}, {31'b0, m_err});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.flush = 0; bus.exc_pc = '0;
        bus.branch_flag = 0; bus.branch_addr = '0; bus.rom_ready = 1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_model();
        chk("reset_pc", bus.pc, RST_PC);
        rst_n = 1'b1;
        #1;
        chk("init_rom_en", {31'b0, bus.rom_en}, 32'd0);

        // Boot sequence: first fetch is RESET_PC
        step(); chk("boot0", bus.pc, 32'hBFC0_0000);
        chk("boot_rom_en", {31'b0, bus.rom_en}, 32'd1);
        step(); chk("boot1", bus.pc, 32'hBFC0_0004);
        step(); chk("boot2", bus.pc, 32'hBFC0_0008);

        // Branch with advance lands next cycle
        bus.branch_flag = 1; bus.branch_addr = 32'hBFC0_0100;
        step(); chk("br_taken", bus.pc, 32'hBFC0_0100);
        chk("br_no_pend", {31'b0, bus.branch_pending}, 32'd0);
        bus.branch_flag = 0;
        step(); chk("br_seq", bus.pc, 32'hBFC0_0104);

        // Branch during a 3-cycle stall is buffered
        bus.stall = 1; bus.branch_flag = 1; bus.branch_addr = 32'h8000_0040;
        step(); chk("stall_hold0", bus.pc, 32'hBFC0_0104);
        chk("stall_pend", {31'b0, bus.branch_pending}, 32'd1);
        bus.branch_flag = 0;
        step(); step(); chk("stall_hold2", bus.pc, 32'hBFC0_0104);
        bus.stall = 0;
        step(); chk("pend_apply", bus.pc, 32'h8000_0040);
        chk("pend_clr", {31'b0, bus.branch_pending}, 32'd0);

        // Flush kills a buffered branch, even under stall
        bus.stall = 1; bus.branch_flag = 1; bus.branch_addr = 32'h8000_0040;
        step();
        bus.branch_flag = 0; bus.flush = 1; bus.exc_pc = 32'hBFC0_0380;
        step(); chk("flush_pc", bus.pc, 32'hBFC0_0380);
        chk("flush_pend", {31'b0, bus.branch_pending}, 32'd0);
        bus.flush = 0; bus.stall = 0;
        step(); chk("flush_no_stale", bus.pc, 32'hBFC0_0384);

        // 32-bit wrap
        bus.branch_flag = 1; bus.branch_addr = 32'hFFFF_FFF8;
        step(); bus.branch_flag = 0;
        step(); chk("wrap_fc", bus.pc, 32'hFFFF_FFFC);
        step(); chk("wrap_0", bus.pc, 32'h0000_0000);

        // Misaligned target
        bus.branch_flag = 1; bus.branch_addr = 32'h8000_0042;
        step(); bus.branch_flag = 0;
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_pc", bus.pc, 32'h8000_0040);
        chk("mis_err", {31'b0, bus.addr_err}, 32'd1);
        step(); chk("mis_next", bus.pc, 32'h8000_0044);
        chk("mis_err_clr", {31'b0, bus.addr_err}, 32'd0);
`else
        chk("mis_pc", bus.pc, 32'h8000_0042);
        chk("mis_err", {31'b0, bus.addr_err}, 32'd0);
        step(); chk("mis_next", bus.pc, 32'h8000_0046);
`endif

        // Stall with rom not ready: repeated branch is idempotent, latest wins
        bus.rom_ready = 0; bus.branch_flag = 1; bus.branch_addr = 32'h1234_5670;
        step(); step();
        bus.branch_addr = 32'h2000_0000;
        step(); bus.branch_flag = 0; bus.rom_ready = 1;
        step(); chk("latest_pend", bus.pc, 32'h2000_0000);

        // Randomized phase with occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.rom_ready   = ($urandom_range(0, 4) != 0);
            bus.flush       = ($urandom_range(0, 19) == 0);
            bus.exc_pc      = $urandom;
            bus.branch_flag = ($urandom_range(0, 4) == 0);
            bus.branch_addr = $urandom;
            if ($urandom_range(0, 3) != 0) bus.branch_addr[1:0] = 2'b00;
            step();
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                check_model();
                #1 rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
IF-stage program-counter generator and consumer of the ID-stage branch resolution (branch_flag/branch_addr). It holds the fetch PC, drives the instruction-ROM request and selects the next PC from sequential, branch, pending-branch and flush sources. Branch taps are taken in ID, so the instruction already in IF is the delay slot. The redirect applies to the next fetch accepted after the branch is seen.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset.
PC_STEP, 4, sequential increment in bytes.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hazard-unit stall of IF; PC must hold.
flush  in  1  exception/eret redirect; highest priority.
exc_pc  in  32  redirect target, valid with flush.
branch_flag  in  1  ID branch/jump taken this cycle.
branch_addr  in  32  ID branch/jump target, valid with branch_flag.
rom_ready  in  1  instruction memory accepts the current request.
rom_en  out  1  fetch request valid.
pc  out  32  current fetch address (rom address and IF/ID pc).
branch_pending  out  1  a taken branch is buffered, not yet applied.
addr_err  out  1  misaligned fetch target (see Optional Feature).

Behaviour:
- Async reset: pc=RESET_PC, rom_en=0, branch_pending=0, pend_addr=0, addr_err=0, state=INIT.
- States: INIT, RUN, HOLD. HOLD means a branch is buffered; branch_pending equals (state==HOLD).
- INIT: rom_en=0 and pc holds. Next edge goes to RUN. pc stays RESET_PC, so the first fetch is RESET_PC with no increment. If flush is high in INIT: pc<=exc_pc, then RUN.
- rom_en=1 in RUN and HOLD.
- advance = rom_ready & ~stall, evaluated in RUN or HOLD.
- Next-PC priority on each edge, RUN or HOLD:
  1. flush: pc<=exc_pc, pending cleared, state RUN. Overrides stall, rom_ready and branch_flag.
  2. advance & branch_flag: pc<=branch_addr, pending cleared, RUN. A new branch beats an older pending one.
  3. advance & HOLD: pc<=pend_addr, pending cleared, RUN.
  4. advance: pc<=pc+PC_STEP, 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
  5. ~advance & branch_flag: pend_addr<=branch_addr, state HOLD. pc holds. A repeat or overwrite while in HOLD keeps the latest target.
  6. Otherwise pc, pend_addr and state hold.
- Latency: a branch_flag seen in a cycle with advance=1 appears on pc one cycle later. A buffered branch appears one cycle after the first advance.
- Stall held for N cycles: pc constant, rom_en stays 1, and only one pending entry is kept.
- A stall from ID that re-presents the same branch_flag for several cycles is idempotent.
- Reset asserted mid-operation: immediate async return to reset values, and any pending branch is lost.
- No combinational path from inputs to pc or branch_pending; both are registered. rom_en depends only on state.

Optional Feature:
PC_ALIGN_CHECK_EN.
- Defined: when a branch or pending target is loaded (cases 2/3) and target[1:0]!=0:
  - pc<={target[31:2],2'b00};
  - addr_err=1 for exactly the cycles that pc value is presented;
  - addr_err clears on the next pc change or flush.
- Defined: exc_pc is not checked.
- Undefined: targets load unchanged, and addr_err is tied 0.

Test Plan:
1. Release rst_n, rom_ready=1, no stall -> rom_en=0 for one cycle, then pc = BFC00000, BFC00004, BFC00008.
2. At pc=BFC00008 pulse branch_flag with branch_addr=BFC00100, one cycle, no stall -> next pc=BFC00100, then BFC00104; branch_pending stays 0.
3. stall=1 for 3 cycles with branch_flag pulsed (addr 0x80000040) in the first stall cycle:
   - pc holds and branch_pending=1;
   - after stall drops, pc=0x80000040 next cycle and branch_pending=0.
4. In HOLD (pend 0x80000040), flush=1 with exc_pc=BFC00380 while stall=1 -> pc=BFC00380 and branch_pending=0; 0x80000040 is never fetched.
5. pc forced near the top via branch to FFFFFFF8, free run -> FFFFFFFC then 00000000.
6. With PC_ALIGN_CHECK_EN defined, branch_addr=0x80000042 -> pc=0x80000040 with addr_err=1 for one cycle, then pc=0x80000044 with addr_err=0.
